// File: rtl/data_bus_arbiter.sv
// data_bus_arbiter: shares one req/ack data-memory port between two 64-bit
// requesters (port 0 = CPU load/store, port 1 = loader/debug DMA) with
// round-robin arbitration, a per-transaction watchdog and registered outputs.
module data_bus_arbiter #(
  parameter int unsigned DATA_W  = 64,
  parameter int unsigned ADDR_W  = 64,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              p0_req,
  input  logic              p0_we,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  output logic              p0_ack,
  output logic              p0_err,
  output logic [DATA_W-1:0] p0_rdata,
  input  logic              p1_req,
  input  logic              p1_we,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic              p1_ack,
  output logic              p1_err,
  output logic [DATA_W-1:0] p1_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              gnt_id
);

  localparam int unsigned TW = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TLAST = TW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_RESP} state_t;

  state_t            state_q, state_d;
  logic [TW-1:0]     timer_q, timer_d;
  logic              last_gnt_q, last_gnt_d;
  logic              gnt_id_q, gnt_id_d;
  logic              busy_q, busy_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              p0_ack_q, p0_ack_d, p1_ack_q, p1_ack_d;
  logic              p0_err_q, p0_err_d, p1_err_q, p1_err_d;
  logic [DATA_W-1:0] p0_rdata_q, p0_rdata_d, p1_rdata_q, p1_rdata_d;
  logic              win;
  logic              done;
  logic              timed_out;

  // Next-state and next-output computation for the IDLE/BUSY/RESP sequencer
  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    last_gnt_d  = last_gnt_q;
    gnt_id_d    = gnt_id_q;
    busy_d      = busy_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    p0_ack_d    = p0_ack_q;
    p0_err_d    = p0_err_q;
    p0_rdata_d  = p0_rdata_q;
    p1_ack_d    = p1_ack_q;
    p1_err_d    = p1_err_q;
    p1_rdata_d  = p1_rdata_q;
    win         = 1'b0;
    done        = 1'b0;
    timed_out   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (p0_req || p1_req) begin
          // On a tie the port that did not win last time goes next
          win         = (p0_req && p1_req) ? ~last_gnt_q : p1_req;
          mem_req_d   = 1'b1;
          mem_we_d    = win ? p1_we    : p0_we;
          mem_addr_d  = win ? p1_addr  : p0_addr;
          mem_wdata_d = win ? p1_wdata : p0_wdata;
          gnt_id_d    = win;
          timer_d     = '0;
          busy_d      = 1'b1;
          state_d     = S_BUSY;
        end
      end
      S_BUSY: begin
        if (mem_ack) begin
          done = 1'b1;
        end else if ((TIMEOUT != 0) && (timer_q == TLAST)) begin
          done      = 1'b1;
          timed_out = 1'b1;
        end else if (timer_q != '1) begin
          timer_d = timer_q + TW'(1);
        end
        if (done) begin
          mem_req_d   = 1'b0;
          mem_we_d    = 1'b0;
          mem_addr_d  = '0;
          mem_wdata_d = '0;
          state_d     = S_RESP;
          if (gnt_id_q) begin
            p1_ack_d   = 1'b1;
            p1_err_d   = timed_out;
            p1_rdata_d = (timed_out || mem_we_q) ? '0 : mem_rdata;
          end else begin
            p0_ack_d   = 1'b1;
            p0_err_d   = timed_out;
            p0_rdata_d = (timed_out || mem_we_q) ? '0 : mem_rdata;
          end
        end
      end
      S_RESP: begin
        p0_ack_d   = 1'b0;
        p0_err_d   = 1'b0;
        p0_rdata_d = '0;
        p1_ack_d   = 1'b0;
        p1_err_d   = 1'b0;
        p1_rdata_d = '0;
        last_gnt_d = gnt_id_q;
        gnt_id_d   = 1'b0;
        busy_d     = 1'b0;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers; reset drops an in-flight memory access at once
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      timer_q     <= '0;
      last_gnt_q  <= 1'b1;
      gnt_id_q    <= 1'b0;
      busy_q      <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      p0_ack_q    <= 1'b0;
      p0_err_q    <= 1'b0;
      p0_rdata_q  <= '0;
      p1_ack_q    <= 1'b0;
      p1_err_q    <= 1'b0;
      p1_rdata_q  <= '0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      last_gnt_q  <= last_gnt_d;
      gnt_id_q    <= gnt_id_d;
      busy_q      <= busy_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      p0_ack_q    <= p0_ack_d;
      p0_err_q    <= p0_err_d;
      p0_rdata_q  <= p0_rdata_d;
      p1_ack_q    <= p1_ack_d;
      p1_err_q    <= p1_err_d;
      p1_rdata_q  <= p1_rdata_d;
    end
  end

  assign p0_ack    = p0_ack_q;
  assign p0_err    = p0_err_q;
  assign p0_rdata  = p0_rdata_q;
  assign p1_ack    = p1_ack_q;
  assign p1_err    = p1_err_q;
  assign p1_rdata  = p1_rdata_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign busy      = busy_q;
  assign gnt_id    = gnt_id_q;

endmodule

// File: tb/tb_data_bus_arbiter.sv
// Self-checking bench for data_bus_arbiter: directed scenarios plus random
// transactions checked against a transaction-level reference model.
module tb_data_bus_arbiter;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        p0_req, p0_we, p1_req, p1_we;
  logic [63:0] p0_addr, p0_wdata, p1_addr, p1_wdata;
  logic        p0_ack, p0_err, p1_ack, p1_err;
  logic [63:0] p0_rdata, p1_rdata;
  logic        mem_req, mem_we, mem_ack;
  logic [63:0] mem_addr, mem_wdata, mem_rdata;
  logic        busy, gnt_id;

  int checks = 0;
  int errors = 0;
  logic last_win;

  data_bus_arbiter #(.DATA_W(64), .ADDR_W(64), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_ack(p0_ack), .p0_err(p0_err), .p0_rdata(p0_rdata),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_ack(p1_ack), .p1_err(p1_err), .p1_rdata(p1_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .busy(busy), .gnt_id(gnt_id)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Checks that the block is quiescent: nothing granted, nothing acknowledged
  task automatic chk_idle(input string tag);
    chk1({tag, "_busy"}, busy, 1'b0);
    chk1({tag, "_gnt"}, gnt_id, 1'b0);
    chk1({tag, "_mreq"}, mem_req, 1'b0);
    chk1({tag, "_ack0"}, p0_ack, 1'b0);
    chk1({tag, "_ack1"}, p1_ack, 1'b0);
  endtask

  // Idle cycles with no requests; optionally a stray mem_ack each cycle
  task automatic idle(input int n, input bit stray);
    for (int i = 0; i < n; i++) begin
      p0_req = 1'b0; p1_req = 1'b0;
      mem_ack = stray ? 1'b1 : 1'b0;
      mem_rdata = {$urandom, $urandom};
      @(posedge clk); #1;
      chk_idle("idle");
      chk1("idle_err0", p0_err, 1'b0);
      chk("idle_rd0", p0_rdata, 64'd0);
    end
    mem_ack = 1'b0;
  endtask

  // One transaction. Called one step after a rising edge with the DUT in IDLE.
  // d = number of cycles the memory waits after mem_req rises; d >= TO means
  // the memory never answers and the watchdog must end the transaction.
  task automatic txn(input bit rq0, input bit rq1, input logic we0, input logic we1,
                     input logic [63:0] ad0, input logic [63:0] ad1,
                     input logic [63:0] wd0, input logic [63:0] wd1,
                     input logic [63:0] rd, input int d);
    logic        w, ewe, tmo;
    logic [63:0] ead, ewd, erd;
    int          ce;
    w   = (rq0 && rq1) ? ~last_win : rq1;
    ewe = w ? we1 : we0;
    ead = w ? ad1 : ad0;
    ewd = w ? wd1 : wd0;
    tmo = (d >= TO);
    ce  = tmo ? TO : d + 1;
    erd = (tmo || ewe) ? 64'd0 : rd;

    p0_req = rq0; p0_we = we0; p0_addr = ad0; p0_wdata = wd0;
    p1_req = rq1; p1_we = we1; p1_addr = ad1; p1_wdata = wd1;
    mem_ack = 1'b0;
    @(posedge clk); #1;
    chk1("grant_busy", busy, 1'b1);
    chk1("grant_gnt", gnt_id, w);
    chk1("grant_mreq", mem_req, 1'b1);
    chk1("grant_mwe", mem_we, ewe);
    chk("grant_maddr", mem_addr, ead);
    chk("grant_mwdata", mem_wdata, ewd);

    for (int k = 1; k <= ce; k++) begin
      mem_ack   = (!tmo && k == d + 1);
      mem_rdata = mem_ack ? rd : {$urandom, $urandom};
      // requester fields wander mid-transaction; the latched request must not
      p0_addr = {$urandom, $urandom}; p1_addr = {$urandom, $urandom};
      p0_wdata = {$urandom, $urandom}; p1_wdata = {$urandom, $urandom};
      p0_we = 1'($urandom); p1_we = 1'($urandom);
      @(posedge clk); #1;
      if (k < ce) begin
        chk1("wait_mreq", mem_req, 1'b1);
        chk("wait_maddr", mem_addr, ead);
        chk1("wait_mwe", mem_we, ewe);
        chk1("wait_gnt", gnt_id, w);
        chk1("wait_ack0", p0_ack, 1'b0);
        chk1("wait_ack1", p1_ack, 1'b0);
      end
    end

    // response cycle; a stray mem_ack here must be dropped
    mem_ack = 1'($urandom);
    chk1("resp_ack0", p0_ack, !w);
    chk1("resp_ack1", p1_ack, w);
    chk1("resp_err0", p0_err, !w && tmo);
    chk1("resp_err1", p1_err, w && tmo);
    chk("resp_rd0", p0_rdata, w ? 64'd0 : erd);
    chk("resp_rd1", p1_rdata, w ? erd : 64'd0);
    chk1("resp_mreq", mem_req, 1'b0);
    chk1("resp_busy", busy, 1'b1);
    chk1("resp_gnt", gnt_id, w);
    if (w) p1_req = 1'b0; else p0_req = 1'b0;
    @(posedge clk); #1;
    chk_idle("post");
    chk1("post_err0", p0_err, 1'b0);
    chk1("post_err1", p1_err, 1'b0);
    last_win = w;
    mem_ack = 1'b0;
  endtask

  initial begin
    rst = 1'b0; last_win = 1'b1;
    p0_req = 0; p0_we = 0; p0_addr = '0; p0_wdata = '0;
    p1_req = 0; p1_we = 0; p1_addr = '0; p1_wdata = '0;
    mem_ack = 0; mem_rdata = '0;
    repeat (3) @(posedge clk);
    #1;
    chk_idle("reset");
    chk("reset_maddr", mem_addr, 64'd0);
    chk("reset_rd1", p1_rdata, 64'd0);
    rst = 1'b1;
    @(posedge clk); #1;

    // p0 read, memory answers 3 cycles after mem_req rises
    txn(1, 0, 0, 0, 64'h100, 64'h0, 64'h0, 64'h0, 64'hDEADBEEF, 3);
    // p1 write, memory answers in the cycle mem_req rises
    txn(0, 1, 0, 1, 64'h0, 64'h20, 64'h0, 64'h55, 64'h1234, 0);
    // both requesting continuously: grants must alternate
    for (int i = 0; i < 6; i++)
      txn(1, 1, 1'($urandom), 1'($urandom), {$urandom, $urandom}, {$urandom, $urandom},
          {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom}, i % 3);
    // watchdog expiry on a p0 read, then late acks in IDLE
    txn(1, 0, 0, 0, 64'h100, 64'h0, 64'h0, 64'h0, 64'hCAFE, 99);
    idle(2, 1);

    // leave p0 as last winner, then reset while p1 is being served
    txn(1, 0, 0, 0, 64'h40, 64'h0, 64'h0, 64'h0, 64'h77, 1);
    p1_req = 1'b1; p1_we = 1'b0; p1_addr = 64'h300;
    @(posedge clk); #1;
    chk1("pre_rst_gnt", gnt_id, 1'b1);
    p1_req = 1'b0;
    @(posedge clk); #3;
    rst = 1'b0;
    #1;
    chk1("async_mreq", mem_req, 1'b0);
    chk1("async_busy", busy, 1'b0);
    chk1("async_gnt", gnt_id, 1'b0);
    @(posedge clk); #1;
    rst = 1'b1;
    last_win = 1'b1;
    txn(1, 1, 0, 0, 64'h100, 64'h200, 64'h0, 64'h0, 64'h99, 2);

    // random traffic
    for (int i = 0; i < 40; i++) begin
      bit r0, r1;
      r0 = 1'($urandom); r1 = 1'($urandom);
      if (!r0 && !r1) r0 = 1'b1;
      txn(r0, r1, 1'($urandom), 1'($urandom), {$urandom, $urandom}, {$urandom, $urandom},
          {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom},
          int'($urandom_range(0, TO + 1)));
      if ($urandom_range(0, 3) == 0) idle(1, 1'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/data_bus_arbiter.md
Name: data_bus_arbiter

Overview:
- Shares the single data-memory port between two 64-bit requesters: port 0 (CPU load/store path) and port 1 (program loader/debug DMA).
- Sits between the CPU's address/data/control buses and a variable-latency data memory that uses a req/ack handshake.
- Serialises requests with round-robin arbitration and a per-transaction watchdog.
- Returns read data or an error to the granted requester.

Parameters:
- DATA_W, 64, width of data buses.
- ADDR_W, 64, width of address buses.
- TIMEOUT, 16, BUSY cycles without mem_ack before the transaction is aborted with error. 0 disables the watchdog.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- p0_req  in  1  port 0 request; held stable until p0_ack.
- p0_we  in  1  port 0 write (1) / read (0).
- p0_addr  in  ADDR_W  port 0 address.
- p0_wdata  in  DATA_W  port 0 write data.
- p0_ack  out  1  port 0 completion, one-cycle pulse.
- p0_err  out  1  port 0 timeout error; valid with p0_ack.
- p0_rdata  out  DATA_W  port 0 read data; valid with p0_ack.
- p1_req, p1_we, p1_addr, p1_wdata, p1_ack, p1_err, p1_rdata: same as port 0, for port 1.
- mem_req  out  1  memory request, held until mem_ack or timeout.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_ack  in  1  memory completion.
- mem_rdata  in  DATA_W  memory read data; valid with mem_ack.
- busy  out  1  high whenever state != IDLE.
- gnt_id  out  1  port owning the current transaction; 0 when idle.

Behaviour:
- States: IDLE, BUSY, RESP. All outputs are registered.
- Reset (rst=0, asynchronous, any state including mid-transaction):
  - state=IDLE; every output 0; timer=0; last_gnt=1, so port 0 wins the first tie.
  - mem_req drops immediately; an abandoned memory access is not replayed.
- IDLE:
  - Sample p0_req/p1_req at each rising edge.
  - If exactly one is high, grant it. If both are high, grant the port != last_gnt.
  - On grant: latch we/addr/wdata of the winner into mem_we/mem_addr/mem_wdata; set mem_req=1, gnt_id=winner, timer=0; go to BUSY.
  - No request: stay in IDLE; mem_* hold 0.
- BUSY:
  - mem_req and mem_* stay stable; requester inputs are ignored (no mid-transaction change).
  - mem_ack=1 at an edge:
    - mem_req=0.
    - For reads, capture mem_rdata into the winner's rdata; for writes, rdata=0.
    - err=0; go to RESP.
  - Else, if TIMEOUT!=0 and timer==TIMEOUT-1:
    - mem_req=0; rdata=0; err=1; go to RESP.
  - Otherwise timer+1. Timer saturates and never wraps; when TIMEOUT=0, BUSY waits indefinitely.
- RESP:
  - Winner's ack=1 for exactly this one cycle; err/rdata valid alongside it. The other port's ack/err/rdata stay 0.
  - At the next edge: ack=0, err=0, rdata=0, last_gnt=gnt_id, gnt_id=0, go to IDLE.
  - mem_ack in RESP or IDLE is ignored (spurious/late acks are dropped).
- Latency:
  - req sampled at edge E0 → mem_req high after E0.
  - mem_ack sampled at edge Ek → ack high after Ek for one cycle.
  - Minimum is 2 cycles from grant edge to ack; maximum throughput is one transaction per 3 cycles.
- Requester rule: deassert req in the ack cycle or earlier. A req still high when IDLE re-samples is a new transaction.
- Fairness: with both ports continuously requesting, grants strictly alternate 0,1,0,1.
- Widths: timer is ceil(log2(TIMEOUT+1)) bits. No arithmetic is performed on address or data.

Test Plan:
- Reset, then p0 read of addr 0x100; memory acks 3 cycles after mem_req with rdata 0xDEADBEEF → p0_ack pulse one cycle after mem_ack, p0_rdata=0xDEADBEEF, p0_err=0, p1_ack never high.
- p0 and p1 both request from the first cycle after reset and hold req high (re-asserting after each ack) → grant order 0,1,0,1 on gnt_id; each ack goes to the matching port only.
- p1 write addr 0x20, wdata 0x55; memory acks in the same cycle mem_req rises → mem_we=1, mem_addr=0x20, mem_wdata=0x55; p1_ack 2 cycles after grant; p1_rdata=0.
- TIMEOUT=4, memory never acks on p0 read → mem_req high exactly 4 cycles, then p0_ack=1 with p0_err=1, p0_rdata=0; a late mem_ack in IDLE is ignored.
- rst driven low while in BUSY → mem_req, busy and gnt_id fall asynchronously; after release, p1 and p0 request together → p0 granted first.
- p0 changes addr from 0x100 to 0x200 mid-BUSY → mem_addr stays 0x100 until completion.
